// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operand-stack controller:
// command codes, ALU op codes, response error codes and FSM states.
package calc_pkg;

    localparam logic [1:0] CMD_PUSH  = 2'b00;
    localparam logic [1:0] CMD_POP   = 2'b01;
    localparam logic [1:0] CMD_OP    = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    localparam logic [3:0] OP_NONE = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_DIV  = 4'b1000;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_UNDER   = 2'b01;
    localparam logic [1:0] ERR_FULL    = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    // Only the four one-hot codes are operations the ALU understands.
    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/calc_stack_ctrl_if.sv
// Command/response channel between the front-end parser (master) and the
// operand-stack controller (slave).
interface calc_stack_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_code;
    logic [DATA_W-1:0] cmd_data;
    logic [3:0]        cmd_op;
    logic              rsp_valid;
    logic [1:0]        rsp_err;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_code, cmd_data, cmd_op,
        input  cmd_ready, rsp_valid, rsp_err, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_code, cmd_data, cmd_op,
        output cmd_ready, rsp_valid, rsp_err, rsp_data
    );
endinterface

// File: rtl/calc_stack_mem.sv
// LIFO storage: DEPTH x DATA_W register array with one write port and two
// asynchronous read ports (top and second-from-top). Contents are not reset.
module calc_stack_mem #(
    parameter  int DEPTH  = 8,
    parameter  int DATA_W = 32,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     top_addr,
    input  logic [AW-1:0]     next_addr,
    output logic [DATA_W-1:0] top_data,
    output logic [DATA_W-1:0] next_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Addresses past DEPTH only occur when the stack is too shallow to care.
    assign top_data  = (32'(top_addr)  < DEPTH) ? mem[top_addr]  : '0;
    assign next_data = (32'(next_addr) < DEPTH) ? mem[next_addr] : '0;

endmodule

// File: rtl/calc_stack_ctrl.sv
// Operand-stack controller driving a combinational 32-bit ALU.
// Optional feature macro CALC_DIV0_TRAP_EN: reject divide-by-zero at acceptance.
module calc_stack_ctrl
    import calc_pkg::*;
#(
    parameter  int DEPTH  = 8,
    parameter  int DATA_W = 32,
    localparam int PTR_W  = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    calc_stack_ctrl_if.slave   bus,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [3:0]         alu_op,
    input  logic [DATA_W-1:0]  alu_y,
    input  logic               alu_overflow,
    output logic [PTR_W-1:0]   depth,
    output logic               ovf_sticky
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] CNT_FULL = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] CNT_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] CNT_TWO  = PTR_W'(2);

    state_t            state, state_nx;
    logic [PTR_W-1:0]  depth_nx;
    logic              ovf_nx;
    logic [DATA_W-1:0] alu_a_nx, alu_b_nx;
    logic [3:0]        alu_op_nx;
    logic              rsp_valid_q, rsp_valid_nx;
    logic [1:0]        rsp_err_q, rsp_err_nx;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_nx;

    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [AW-1:0]     top_addr, next_addr;
    logic [DATA_W-1:0] top_data, next_data;
    logic [DATA_W-1:0] top_val;
    logic              accept;

    calc_stack_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk       (clk),
        .we        (mem_we),
        .waddr     (mem_waddr),
        .wdata     (mem_wdata),
        .top_addr  (top_addr),
        .next_addr (next_addr),
        .top_data  (top_data),
        .next_data (next_data)
    );

    assign top_addr  = AW'(depth - CNT_ONE);
    assign next_addr = AW'(depth - CNT_TWO);
    assign top_val   = (depth != '0) ? top_data : '0;
    assign accept    = bus.cmd_valid && (state == IDLE);

    assign bus.cmd_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data  = rsp_data_q;

    // Every registered output is computed here; a response is prepared on the
    // same edge that enters RESP so rsp_valid is high exactly while in RESP.
    always_comb begin
        state_nx     = state;
        depth_nx     = depth;
        ovf_nx       = ovf_sticky;
        alu_a_nx     = alu_a;
        alu_b_nx     = alu_b;
        alu_op_nx    = alu_op;
        rsp_valid_nx = 1'b0;
        rsp_err_nx   = rsp_err_q;
        rsp_data_nx  = rsp_data_q;
        mem_we       = 1'b0;
        mem_waddr    = AW'(depth);
        mem_wdata    = bus.cmd_data;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx     = RESP;
                    rsp_valid_nx = 1'b1;
                    rsp_err_nx   = ERR_OK;
                    rsp_data_nx  = top_val;
                    case (bus.cmd_code)
                        CMD_PUSH: begin
                            if (depth == CNT_FULL) begin
                                rsp_err_nx = ERR_FULL;
                            end else begin
                                mem_we      = 1'b1;
                                depth_nx    = depth + CNT_ONE;
                                rsp_data_nx = bus.cmd_data;
                            end
                        end
                        CMD_POP: begin
                            if (depth == '0) begin
                                rsp_err_nx = ERR_UNDER;
                            end else begin
                                depth_nx    = depth - CNT_ONE;
                                rsp_data_nx = (depth >= CNT_TWO) ? next_data : '0;
                            end
                        end
                        CMD_CLEAR: begin
                            depth_nx    = '0;
                            ovf_nx      = 1'b0;
                            rsp_data_nx = '0;
                        end
                        default: begin
                            if (!is_legal_op(bus.cmd_op)) begin
                                rsp_err_nx = ERR_ILLEGAL;
                            end else if (depth < CNT_TWO) begin
                                rsp_err_nx = ERR_UNDER;
`ifdef CALC_DIV0_TRAP_EN
                            end else if ((bus.cmd_op == OP_DIV) && (top_data == '0)) begin
                                rsp_err_nx = ERR_ILLEGAL;
`endif
                            end else begin
                                state_nx     = EXEC;
                                rsp_valid_nx = 1'b0;
                                alu_a_nx     = next_data;
                                alu_b_nx     = top_data;
                                alu_op_nx    = bus.cmd_op;
                            end
                        end
                    endcase
                end
            end
            EXEC: begin
                // Result overwrites the second entry; overflow only flags.
                state_nx     = RESP;
                mem_we       = 1'b1;
                mem_waddr    = next_addr;
                mem_wdata    = alu_y;
                depth_nx     = depth - CNT_ONE;
                ovf_nx       = ovf_sticky | alu_overflow;
                alu_op_nx    = OP_NONE;
                rsp_valid_nx = 1'b1;
                rsp_err_nx   = ERR_OK;
                rsp_data_nx  = alu_y;
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and output registers; stack contents live in calc_stack_mem.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            depth       <= '0;
            ovf_sticky  <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= OP_NONE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= ERR_OK;
            rsp_data_q  <= '0;
        end else begin
            state       <= state_nx;
            depth       <= depth_nx;
            ovf_sticky  <= ovf_nx;
            alu_a       <= alu_a_nx;
            alu_b       <= alu_b_nx;
            alu_op      <= alu_op_nx;
            rsp_valid_q <= rsp_valid_nx;
            rsp_err_q   <= rsp_err_nx;
            rsp_data_q  <= rsp_data_nx;
        end
    end

endmodule

// File: doc/calc_stack_ctrl.md
Name: calc_stack_ctrl

Overview:
Operand-stack controller that drives the calculator's combinational 32-bit ALU (one-hot op: 0001 add, 0010 sub, 0100 mul, 1000 div). It accepts PUSH/POP/OP/CLEAR commands from the front-end (keypad/queue parser) over a valid/ready handshake. It holds operands in a LIFO register stack and presents the two top entries to the ALU. It writes the ALU result back onto the stack and reports each completion with a one-cycle response.

Parameters:
DEPTH, 8, number of stack entries (≥2). The derived localparam PTR_W = $clog2(DEPTH+1) sizes the count.
DATA_W, 32, operand width; must equal the ALU width.

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_code  in  2  00 PUSH, 01 POP, 10 OP, 11 CLEAR
cmd_data  in  DATA_W  PUSH operand
cmd_op  in  4  ALU op for OP commands (one-hot)
alu_a  out  DATA_W  ALU operand A (second-from-top)
alu_b  out  DATA_W  ALU operand B (top)
alu_op  out  4  ALU op; 4'b0000 when idle
alu_y  in  DATA_W  ALU result
alu_overflow  in  1  ALU overflow bit
rsp_valid  out  1  one-cycle completion pulse
rsp_err  out  2  00 ok, 01 underflow, 10 full, 11 illegal op/div-by-zero trap
rsp_data  out  DATA_W  top of stack after command (0 if empty)
depth  out  PTR_W  current entry count
ovf_sticky  out  1  set by any ALU overflow; cleared by CLEAR or reset

Behaviour:
- One clock domain. rst_n asserted asynchronously forces state IDLE and depth=0. It also forces alu_a=alu_b=0, alu_op=0, rsp_valid=0, rsp_err=0, rsp_data=0 and ovf_sticky=0. Stack array contents are not reset.
- FSM states: IDLE, EXEC, RESP. cmd_ready = (state==IDLE). A command is accepted on a clk edge with cmd_valid & cmd_ready.
- PUSH: if depth==DEPTH, the stack is unchanged and err=10. Otherwise cmd_data is written at index depth and depth increments. IDLE→RESP.
- POP: if depth==0, err=01. Otherwise depth decrements. IDLE→RESP.
- CLEAR: sets depth=0 and ovf_sticky=0. err=00. IDLE→RESP.
- OP: if cmd_op is not one of the four one-hot codes, err=11; if depth<2, err=01. Either error leaves the stack unchanged and goes IDLE→RESP. Otherwise IDLE→EXEC.
- EXEC: registered alu_a=stack[depth-2], alu_b=stack[depth-1] and alu_op=cmd_op are driven for this one cycle. On the EXEC→RESP edge, alu_y is written to stack[depth-2] and depth decrements by 1. ovf_sticky is set if alu_overflow=1, but the result is still written. alu_op returns to 0 on leaving EXEC.
- RESP: rsp_valid=1 for exactly one cycle with rsp_err and rsp_data (the new top, or 0 when depth==0), then the FSM returns to IDLE.
- Latency from acceptance to rsp_valid: 1 cycle for PUSH/POP/CLEAR and errors; 2 cycles for a valid OP. Maximum throughput is one command per 2 cycles (3 for OP).
- Commands are not queued. cmd_valid while cmd_ready=0 is ignored, and the source holds it.
- Division by zero with the feature disabled: the ALU returns 0, which is pushed with err=00.
- Reset mid-EXEC aborts the operation; the stack is empty after reset.

Optional Feature:
CALC_DIV0_TRAP_EN. When defined, an OP with cmd_op=1000 and top entry == 0 is rejected at acceptance. It goes IDLE→RESP with err=11, the stack is unchanged, and the ALU is never driven. When undefined, the division is executed normally and the result 0 is pushed.

Decomposition:
- The shared package calc_pkg holds:
  - cmd_code constants CMD_PUSH/POP/OP/CLEAR
  - ALU op constants OP_ADD=4'b0001, OP_SUB=4'b0010, OP_MUL=4'b0100, OP_DIV=4'b1000, OP_NONE=4'b0000
  - rsp_err constants ERR_OK/UNDER/FULL/ILLEGAL
  - the FSM state enum
- One natural sub-module, calc_stack_mem: a DEPTH×DATA_W register array with write port and two async read ports (top, top-1). The FSM stays in calc_stack_ctrl.

Test Plan:
1. PUSH 7, PUSH 3, OP 0010 → rsp_valid 2 cycles after OP acceptance; alu_a=7, alu_b=3 during EXEC; rsp_data=4, depth=1, err=00.
2. PUSH 0xFFFFFFFF, PUSH 1, OP 0001 → rsp_data=0, ovf_sticky=1; then CLEAR → depth=0, ovf_sticky=0.
3. On an empty stack, POP → err=01; PUSH 5 then OP 0100 → err=01, depth stays 1, alu_op remains 0000.
4. Push DEPTH=8 values 1..8, then PUSH 9 → err=10, depth=8, rsp_data=8.
5. PUSH 9, PUSH 0, OP 1000 → with CALC_DIV0_TRAP_EN: err=11, depth=2, rsp_data=0; without it: err=00, depth=1, rsp_data=0.
6. PUSH 6, PUSH 2, OP 0011 → err=11, depth=2. Then OP 1000 with rst_n pulsed low during EXEC → all outputs 0 immediately, depth=0, cmd_ready=1 after release.
